mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Merges the CPU datapath's two memory ports into one unified memory/cache port.
//  Port A is instruction fetch (read-only). Port B is data (read/write).
//  One transaction is outstanding at a time.
//  Round-robin arbitration on conflict, so a constantly asserted fetch (read_a=1) cannot starve data.
//  Sits directly downstream of cpu_datapath, between it and the unified L1 cache.
// PARAMETERS
//  ADDR_WIDTH  32  byte address width, both sides
//  DATA_WIDTH  32  data word width, both sides
//  CNT_WIDTH   32  width of the saturating conflict counter
// PORTS
//  clk           in   1           system clock, rising edge
//  rst_n         in   1           asynchronous active-low reset
//  read_a        in   1           fetch read request; held until resp_a
//  address_a     in   ADDR_WIDTH  fetch address
//  rdata_a       out  DATA_WIDTH  fetch read data, valid only with resp_a
//  resp_a        out  1           fetch done, 1-cycle pulse
//  read_b        in   1           data read request; held until resp_b
//  write         in   1           data write request; held until resp_b
//  address_b     in   ADDR_WIDTH  data address
//  wdata         in   DATA_WIDTH  write data
//  wmask         in   4           byte write enables
//  rdata_b       out  DATA_WIDTH  data read data, valid only with resp_b
//  resp_b        out  1           data done, 1-cycle pulse
//  mem_read      out  1           downstream read strobe
//  mem_write     out  1           downstream write strobe
//  mem_address   out  ADDR_WIDTH  downstream address (registered)
//  mem_wdata     out  DATA_WIDTH  downstream write data (registered)
//  mem_wmask     out  4           downstream byte mask (registered; 0 on reads)
//  mem_rdata     in   DATA_WIDTH  downstream read data
//  mem_resp      in   1           downstream done, 1-cycle pulse
//  conflict_cnt  out  CNT_WIDTH   count of IDLE cycles with both ports requesting
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, last_grant=B, all latched regs=0, conflict_cnt=0.
//   - All outputs 0 while rst_n=0.
//   - Reset mid-transaction drops mem_read/mem_write immediately; the pending transaction is abandoned.
//  Request definitions: req_a=read_a, req_b=read_b|write.
//  FSM states: IDLE, SERVE_A, SERVE_B.
//  IDLE:
//   - Only req_a: go to SERVE_A. Only req_b: go to SERVE_B.
//   - Both: grant the port opposite last_grant. The first conflict after reset goes to A.
//   - On any grant: latch address, op, wdata and wmask, and set last_grant.
//   - Neither: stay in IDLE.
//  SERVE_x:
//   - mem_read/mem_write are driven from the latched op, starting the cycle after the grant.
//   - Strobes and the latched address/data are held stable until mem_resp.
//   - On mem_resp: resp_x=1 in the same cycle (combinational), rdata_x=mem_rdata, next state IDLE.
//  Timing: grant cycle N -> strobe visible N+1. The IDLE cycle is a mandatory bubble between transactions.
//  rdata_a and rdata_b are both tied to mem_rdata; only the granted port's resp is ever asserted.
//  read_b and write both high: treated as a write. read_a must never see a write.
//  mem_resp while in IDLE: ignored. No resp is generated and the state does not change.
//  A request dropped mid-service does not abort: the transaction completes and resp still pulses.
//  conflict_cnt:
//   - +1 on each IDLE cycle with req_a&req_b.
//   - Saturates at 2^CNT_WIDTH-1; no wrap.
//  A port's changed inputs are sampled only on its next grant.
// TESTING
//  1. Fetch only: read_a=1, address_a=0x60, mem_resp 3 cycles later with mem_rdata=0x00000013
//     -> mem_read=1 and mem_address=0x60 from N+1; resp_a pulses once with rdata_a=0x13.
//  2. Conflict: read_a=1 and write=1 from reset, address_b=0x100, wdata=0xDEADBEEF, wmask=0xF
//     -> A is served first; then mem_write=1 with mem_address=0x100 and mem_wmask=0xF;
//     conflict_cnt=2.
//  3. Fairness: read_a held high plus 4 back-to-back read_b requests
//     -> grants strictly alternate A,B,A,B,...; no B request waits more than one A transaction.
//  4. Stray mem_resp in IDLE -> no resp_a/resp_b, state stays IDLE.
//     read_b=1 and write=1 together -> mem_write=1, mem_read=0.
//  5. Deassert rst_n while in SERVE_B with mem_write=1
//     -> mem_write=0 immediately; resp_b never pulses.
//     After release, the first conflict is granted to A.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port to one-port memory arbiter: fetch port A (read-only) and data port B (read/write)
// share one downstream port, one transaction at a time, round-robin on conflict.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_a,
  input  logic [ADDR_WIDTH-1:0] address_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic                  resp_a,
  input  logic                  read_b,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wmask,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  resp_b,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  typedef enum logic [1:0] {StIdle, StServeA, StServeB} state_e;

  state_e                  state_q;
  logic                    last_grant_b_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [3:0]              wmask_q;
  logic                    op_write_q;
  logic [CNT_WIDTH-1:0]    cnt_q;

  logic req_a, req_b, grant_a, grant_b;

  assign req_a = read_a;
  assign req_b = read_b | write;

  // On conflict the port that did not win last time gets the grant.
  assign grant_a = req_a & (~req_b | last_grant_b_q);
  assign grant_b = req_b & (~req_a | ~last_grant_b_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      last_grant_b_q <= 1'b1;
      addr_q         <= '0;
      wdata_q        <= '0;
      wmask_q        <= '0;
      op_write_q     <= 1'b0;
      cnt_q          <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_a && req_b && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
          if (grant_a) begin
            state_q        <= StServeA;
            last_grant_b_q <= 1'b0;
            addr_q         <= address_a;
            op_write_q     <= 1'b0;
            wdata_q        <= '0;
            wmask_q        <= '0;
          end else if (grant_b) begin
            state_q        <= StServeB;
            last_grant_b_q <= 1'b1;
            addr_q         <= address_b;
            // Simultaneous read_b and write is a write.
            op_write_q     <= write;
            wdata_q        <= wdata;
            wmask_q        <= write ? wmask : 4'h0;
          end
        end
        StServeA, StServeB: begin
          if (mem_resp) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_read     = (state_q != StIdle) & ~op_write_q;
  assign mem_write    = (state_q != StIdle) & op_write_q;
  assign mem_address  = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_wmask    = wmask_q;
  assign conflict_cnt = cnt_q;

  assign resp_a = (state_q == StServeA) & mem_resp;
  assign resp_b = (state_q == StServeB) & mem_resp;

  // Read data is a pass-through, forced to zero while held in reset.
  assign rdata_a = rst_n ? mem_rdata : '0;
  assign rdata_b = rst_n ? mem_rdata : '0;

endmodule
